// File: rtl/zipmem_pkg.sv
// Shared definitions for the single-line data cache: FSM states and default line size.
package zipmem_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    SINGLE = 2'd2,
    WRITE  = 2'd3
  } state_t;

  localparam int DEF_LGLINE = 3;
endpackage

// File: rtl/dline_cache_if.sv
// Pipelined Wishbone master bundle used between the cache and its memory bus.
interface dline_cache_if #(
  parameter int AW = 30,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   mdata;
  logic [DW/8-1:0] sel;
  logic            stall;
  logic            ack;
  logic            err;
  logic [DW-1:0]   sdata;

  // A strobe transfers on a rising edge when stb is high and stall is low;
  // every transfer is answered by exactly one ack or err while cyc stays high.
  modport master (output cyc, stb, we, addr, mdata, sel,
                  input  stall, ack, err, sdata);
  modport slave  (input  cyc, stb, we, addr, mdata, sel,
                  output stall, ack, err, sdata);
endinterface

// File: rtl/dline_ram.sv
// Line storage: byte-writable word array with a registered read port.
module dline_ram #(
  parameter int LGLINE = 3,
  parameter int DW     = 32
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [LGLINE-1:0] i_waddr,
  input  logic [DW-1:0]     i_wdata,
  input  logic [DW/8-1:0]   i_wsel,
  input  logic [LGLINE-1:0] i_raddr,
  output logic [DW-1:0]     o_rdata
);
  logic [DW-1:0] r_mem [0:(1<<LGLINE)-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (i_wsel[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/dline_cache.sv
// Single-line read cache in front of a pipelined Wishbone master.
// Define DLINE_WRITE_UPDATE_EN to merge write hits into the line instead of invalidating it.
module dline_cache
  import zipmem_pkg::*;
#(
  parameter int AW     = 30,
  parameter int DW     = 32,
  parameter int LGLINE = DEF_LGLINE
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_pipe_stb,
  input  logic            i_we,
  input  logic [AW-1:0]   i_addr,
  input  logic [DW-1:0]   i_data,
  input  logic [DW/8-1:0] i_sel,
  input  logic            i_cachable,
  output logic            o_busy,
  output logic            o_valid,
  output logic            o_err,
  output logic [DW-1:0]   o_data,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data,
  output state_t          o_dbg_state
);
  localparam int TW = AW - LGLINE;
  localparam logic [LGLINE:0] CNT_FULL = (LGLINE+1)'(1 << LGLINE);
  localparam logic [LGLINE:0] CNT_LAST = (LGLINE+1)'((1 << LGLINE) - 1);
  localparam logic [LGLINE:0] CNT_ONE  = (LGLINE+1)'(1);

  dline_cache_if #(.AW(AW), .DW(DW)) wb ();

  state_t            r_state, w_next;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_data;
  logic [DW/8-1:0]   r_sel;
  logic              r_we, r_cachable;
  logic              r_line_valid;
  logic [TW-1:0]     r_tag;
  logic [LGLINE:0]   r_stb_cnt, r_ack_cnt;
  logic              r_valid, r_err, r_use_ram;
  logic [DW-1:0]     r_rdata;

  logic              w_accept, w_tag_match, w_rd_hit;
  logic [LGLINE:0]   w_stb_goal;
  logic              w_stb, w_stb_take, w_ack, w_bus_err, w_last_ack;
  logic              w_ram_we;
  logic [LGLINE-1:0] w_ram_waddr;
  logic [DW-1:0]     w_ram_wdata, w_ram_rdata;
  logic [DW/8-1:0]   w_ram_wsel;

  assign w_accept    = i_pipe_stb && (r_state == IDLE);
  assign w_tag_match = r_line_valid && (r_tag == i_addr[AW-1:LGLINE]);
  assign w_rd_hit    = w_accept && !i_we && i_cachable && w_tag_match;

  // Strobes stop once every transfer has been taken; cyc lingers for the acks.
  assign w_stb_goal = (r_state == FILL) ? CNT_FULL : CNT_ONE;
  assign w_stb      = (r_state != IDLE) && (r_stb_cnt < w_stb_goal);
  assign w_stb_take = w_stb && !wb.stall;
  assign w_bus_err  = (r_state != IDLE) && wb.err;
  assign w_ack      = (r_state != IDLE) && wb.ack && !wb.err;
  assign w_last_ack = w_ack && ((r_state != FILL) || (r_ack_cnt == CNT_LAST));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (i_we)                      w_next = WRITE;
          else if (!i_cachable)          w_next = SINGLE;
          else if (!w_tag_match)         w_next = FILL;
        end
      end
      default: begin
        if (w_bus_err || w_last_ack) w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_line_valid <= 1'b0;
      r_stb_cnt    <= '0;
      r_ack_cnt    <= '0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_accept) begin
        r_stb_cnt <= '0;
        r_ack_cnt <= '0;
      end else begin
        if (w_stb_take) r_stb_cnt <= r_stb_cnt + 1'b1;
        if (w_ack)      r_ack_cnt <= r_ack_cnt + 1'b1;
      end
      if (w_rd_hit) r_valid <= 1'b1;
      if (w_accept && !i_we && i_cachable && !w_tag_match) r_line_valid <= 1'b0;
`ifndef DLINE_WRITE_UPDATE_EN
      if (w_accept && i_we && w_tag_match) r_line_valid <= 1'b0;
`endif
      if (w_last_ack) begin
        if (r_state == FILL && r_cachable) r_line_valid <= 1'b1;
        if (!r_we) r_valid <= 1'b1;
      end
      if (w_bus_err) begin
        r_line_valid <= 1'b0;
        r_err        <= 1'b1;
      end
    end
  end

  // Request registers and the returned word; no reset needed, qualified by state.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_addr     <= i_addr;
      r_data     <= i_data;
      r_sel      <= i_sel;
      r_we       <= i_we;
      r_cachable <= i_cachable;
    end
    if (w_last_ack && r_state == FILL) r_tag <= r_addr[AW-1:LGLINE];
    if (w_rd_hit)   r_use_ram <= 1'b1;
    else if (w_ack) r_use_ram <= 1'b0;
    if (w_ack && ((r_state == SINGLE) ||
                  (r_state == FILL && r_ack_cnt[LGLINE-1:0] == r_addr[LGLINE-1:0])))
      r_rdata <= wb.sdata;
  end

  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = r_ack_cnt[LGLINE-1:0];
    w_ram_wdata = wb.sdata;
    w_ram_wsel  = '1;
    if (r_state == FILL && w_ack) w_ram_we = 1'b1;
`ifdef DLINE_WRITE_UPDATE_EN
    if (w_accept && i_we && w_tag_match) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = i_addr[LGLINE-1:0];
      w_ram_wdata = i_data;
      w_ram_wsel  = i_sel;
    end
`endif
  end

  dline_ram #(.LGLINE(LGLINE), .DW(DW)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_wsel  (w_ram_wsel),
    .i_raddr (i_addr[LGLINE-1:0]),
    .o_rdata (w_ram_rdata)
  );

  assign wb.cyc   = (r_state != IDLE);
  assign wb.stb   = w_stb;
  assign wb.we    = r_we;
  assign wb.addr  = (r_state == FILL) ? {r_addr[AW-1:LGLINE], r_stb_cnt[LGLINE-1:0]} : r_addr;
  assign wb.mdata = r_data;
  assign wb.sel   = r_sel;
  assign wb.stall = i_wb_stall;
  assign wb.ack   = i_wb_ack;
  assign wb.err   = i_wb_err;
  assign wb.sdata = i_wb_data;

  assign o_wb_cyc    = wb.cyc;
  assign o_wb_stb    = wb.stb;
  assign o_wb_we     = wb.we;
  assign o_wb_addr   = wb.addr;
  assign o_wb_data   = wb.mdata;
  assign o_wb_sel    = wb.sel;
  assign o_busy      = (r_state != IDLE);
  assign o_valid     = r_valid;
  assign o_err       = r_err;
  assign o_data      = r_use_ram ? w_ram_rdata : r_rdata;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_dline_cache.sv
// Randomized bench for dline_cache: pipelined Wishbone slave with a backing memory,
// and a line-level cache model that predicts hits, strobe addresses and read data.
module tb_dline_cache;
  import zipmem_pkg::*;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = DW/8;
`ifdef DLINE_WRITE_UPDATE_EN
  localparam bit WR_UPD = 1'b1;
`else
  localparam bit WR_UPD = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b1;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            i_pipe_stb = 1'b0, i_we = 1'b0, i_cachable = 1'b0;
  logic [AW-1:0]   i_addr = '0;
  logic [DW-1:0]   i_data = '0;
  logic [SW-1:0]   i_sel  = '0;
  logic            o_busy, o_valid, o_err;
  logic [DW-1:0]   o_data;
  state_t          dbg_state;

  dline_cache_if #(.AW(AW), .DW(DW)) bus ();

  dline_cache dut (
    .i_clk(clk), .i_reset(rst),
    .i_pipe_stb(i_pipe_stb), .i_we(i_we), .i_addr(i_addr), .i_data(i_data),
    .i_sel(i_sel), .i_cachable(i_cachable),
    .o_busy(o_busy), .o_valid(o_valid), .o_err(o_err), .o_data(o_data),
    .o_wb_cyc(bus.cyc), .o_wb_stb(bus.stb), .o_wb_we(bus.we), .o_wb_addr(bus.addr),
    .o_wb_data(bus.mdata), .o_wb_sel(bus.sel),
    .i_wb_stall(bus.stall), .i_wb_ack(bus.ack), .i_wb_err(bus.err), .i_wb_data(bus.sdata),
    .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // backing memory seen by the slave
  logic [DW-1:0] mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
  } wb_req_t;

  wb_req_t       pend_q[$];
  logic [AW-1:0] exp_q[$];
  bit            zero_stall = 1'b1, force_stall = 1'b0;
  int            err_at = 0, ack_n = 0;
  int            n_valid = 0, n_err = 0, n_stb = 0, stb_viol = 0;
  logic [DW-1:0] got_data = '0;

  // cache model: one line, valid flag and tag
  bit            m_valid = 1'b0;
  logic [AW-4:0] m_tag = '0;

  // slave + monitor, all on the falling edge
  always @(negedge clk) begin
    wb_req_t       r;
    logic [DW-1:0] w;
    bus.ack = 1'b0;
    bus.err = 1'b0;
    if (rst || !bus.cyc) begin
      pend_q.delete();
      ack_n     = 0;
      bus.ack   = ($urandom_range(0, 7) == 0);
      bus.sdata = $urandom;
    end else if (pend_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      r = pend_q.pop_front();
      ack_n++;
      if (err_at != 0 && ack_n == err_at) begin
        bus.err = 1'b1;
        pend_q.delete();
      end else begin
        bus.ack = 1'b1;
        if (r.we) begin
          w = mem_rd(r.addr);
          for (int b = 0; b < SW; b++) if (r.sel[b]) w[b*8 +: 8] = r.data[b*8 +: 8];
          mem[r.addr] = w;
        end else begin
          bus.sdata = mem_rd(r.addr);
        end
      end
    end
    bus.stall = force_stall || (!zero_stall && $urandom_range(0, 2) == 0);
    if (!rst && bus.cyc && bus.stb && !bus.stall) begin
      r.we = bus.we; r.addr = bus.addr; r.data = bus.mdata; r.sel = bus.sel;
      pend_q.push_back(r);
      n_stb++;
      if (exp_q.size() > 0) check("stb_addr", bus.addr, exp_q.pop_front());
      else                  check("stb_unexpected", 1, 0);
    end
    if (bus.stb && !bus.cyc) stb_viol++;
    if (o_valid) begin n_valid++; got_data = o_data; end
    if (o_err) n_err++;
  end

  task automatic pulse_reset();
    @(negedge clk); #1;
    rst = 1'b1; i_pipe_stb = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    m_valid = 1'b0;
    exp_q.delete();
  endtask

  // one CPU request, checked end to end against the model
  task automatic do_req(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [SW-1:0] sel, input bit cach, input int e_at);
    bit hit, done, erred;
    int exp_stb;
    hit = !we && cach && m_valid && (m_tag == addr[AW-1:3]);
    exp_stb = hit ? 0 : (!we && cach) ? 8 : 1;
    if (e_at > exp_stb) e_at = exp_stb;
    erred = (e_at != 0) && !hit;
    exp_q.delete();
    if (exp_stb == 8) for (int k = 0; k < 8; k++) exp_q.push_back({addr[AW-1:3], 3'(k)});
    else if (exp_stb == 1) exp_q.push_back(addr);

    @(negedge clk); #1;
    n_valid = 0; n_err = 0; n_stb = 0; err_at = e_at;
    i_pipe_stb = 1'b1; i_we = we; i_addr = addr; i_data = data; i_sel = sel; i_cachable = cach;
    @(negedge clk); #1;
    i_pipe_stb = 1'b0;
    check("busy_after_accept", o_busy, !hit);
    check("cyc_after_accept", bus.cyc, !hit);
    if (hit) check("hit_valid_next_cycle", o_valid, 1);

    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (!o_busy) done = 1'b1;
      else begin
        // junk strobes while busy must be ignored
        i_pipe_stb = 1'($urandom_range(0, 1)); i_we = 1'($urandom_range(0, 1));
        i_addr = AW'($urandom); i_data = $urandom; i_cachable = 1'($urandom_range(0, 1));
        @(negedge clk); #1;
      end
    end
    i_pipe_stb = 1'b0;
    if (!done) begin
      check("timeout", 1, 0);
      pulse_reset();
      return;
    end
    @(negedge clk); #1;

    check("valid_count", n_valid, (we || erred) ? 0 : 1);
    check("err_count", n_err, erred);
    if (!erred) begin
      check("stb_count", n_stb, exp_stb);
      check("stb_left", exp_q.size(), 0);
      if (!we) check("rdata", got_data, mem_rd(addr));
    end

    if (erred) m_valid = 1'b0;
    else if (!we && cach && !hit) begin m_valid = 1'b1; m_tag = addr[AW-1:3]; end
    else if (we && !WR_UPD && m_valid && m_tag == addr[AW-1:3]) m_valid = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit            we, unc, cach;
    logic [AW-1:0] a;
    logic [SW-1:0] sel;
    int            e_at;

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_cyc", bus.cyc, 0);
    check("rst_stb", bus.stb, 0);
    check("rst_valid", o_valid, 0);
    check("rst_err", o_err, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;

    // line fill then hit
    do_req(0, 30'h100, '0, 4'hF, 1, 0);
    do_req(0, 30'h103, '0, 4'hF, 1, 0);
    // uncached read leaves the line alone
    mem[30'h1000000] = 32'hDEADBEEF;
    do_req(0, 30'h1000000, '0, 4'hF, 0, 0);
    check("uncached_data", got_data, 32'hDEADBEEF);
    do_req(0, 30'h105, '0, 4'hF, 1, 0);
    // write into the cached line, then read it back
    do_req(1, 30'h102, 32'h12345678, 4'hF, 1, 0);
    do_req(0, 30'h102, '0, 4'hF, 1, 0);
    check("write_readback", got_data, 32'h12345678);
    // bus error on the third fill ack, then a full refetch
    do_req(0, 30'h200, '0, 4'hF, 1, 3);
    do_req(0, 30'h100, '0, 4'hF, 1, 0);

    // reset in the middle of a stalled fill
    force_stall = 1'b1;
    @(negedge clk); #1;
    i_pipe_stb = 1'b1; i_we = 1'b0; i_addr = 30'h300; i_cachable = 1'b1; i_sel = 4'hF;
    @(negedge clk); #1;
    i_pipe_stb = 1'b0;
    check("stall_fill_busy", o_busy, 1);
    check("stall_fill_stb", bus.stb, 1);
    @(negedge clk); #1;
    n_valid = 0; n_err = 0;
    rst = 1'b1;
    @(negedge clk); #1;
    check("abort_cyc", bus.cyc, 0);
    check("abort_stb", bus.stb, 0);
    check("abort_busy", o_busy, 0);
    rst = 1'b0; force_stall = 1'b0;
    m_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("abort_no_valid", n_valid, 0);
    check("abort_no_err", n_err, 0);
    do_req(0, 30'h100, '0, 4'hF, 1, 0);

    // randomized mix with a stalling slave
    zero_stall = 1'b0;
    for (int t = 0; t < 60; t++) begin
      we   = ($urandom_range(0, 3) == 0);
      unc  = ($urandom_range(0, 4) == 0);
      cach = !unc;
      if (unc) a = 30'h1000000 + AW'($urandom_range(0, 15));
      else     a = 30'h100 * AW'($urandom_range(1, 3)) + AW'($urandom_range(0, 7));
      sel  = we ? SW'($urandom_range(1, 15)) : 4'hF;
      e_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 8) : 0;
      do_req(we, a, $urandom, sel, cach, e_at);
    end

    check("stb_without_cyc", stb_viol, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/dline_cache.md
DLINE_CACHE -- requirements
Module: dline_cache

Interface
REQ-001 SHALL have parameter AW, default 30: word-address width.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter LGLINE, default 3: log2 of words per cache line (8 words).
REQ-004 SHALL provide i_clk, input, 1: the single clock; all logic on rising edge.
REQ-005 SHALL provide i_reset, input, 1: reset, synchronous and active-high.
REQ-006 SHALL provide i_pipe_stb, input, 1: CPU request strobe.
REQ-007 SHALL provide i_we, input, 1: 1 = write, 0 = read.
REQ-008 SHALL provide i_addr, input, AW: request word address.
REQ-009 SHALL provide i_data, input, DW: write data.
REQ-010 SHALL provide i_sel, input, DW/8: byte enables.
REQ-011 SHALL provide i_cachable, input, 1: combinational cachability of i_addr from the address decoder.
REQ-012 SHALL provide o_busy, output, 1: request in progress; new strobes not accepted.
REQ-013 SHALL provide o_valid, output, 1: one-cycle read-data-valid pulse.
REQ-014 SHALL provide o_err, output, 1: one-cycle bus-error pulse.
REQ-015 SHALL provide o_data, output, DW: read data, qualified by o_valid.
REQ-016 SHALL provide o_wb_cyc, o_wb_stb, o_wb_we (1 each), o_wb_addr (AW), o_wb_data (DW), o_wb_sel (DW/8): pipelined Wishbone master outputs.
REQ-017 SHALL provide i_wb_stall, i_wb_ack, i_wb_err (1 each), i_wb_data (DW): Wishbone master inputs.

Function
REQ-018 SHALL accept a request only when i_pipe_stb && !o_busy; strobes while busy are ignored.
REQ-019 SHALL hold the accepted address, data, sel, we and cachable bit in registers until the request completes.
REQ-020 SHALL use states IDLE, FILL, SINGLE (uncached read), WRITE; o_busy = (state != IDLE).
REQ-021 Read hit (line valid, tag = i_addr[AW-1:LGLINE], i_cachable): no bus cycle, o_valid with word data the cycle after acceptance, state stays IDLE.
REQ-022 Cachable read miss: IDLE->FILL; line valid cleared; issue 2^LGLINE strobes at line base, offsets 0..2^LGLINE-1, advancing only when !i_wb_stall.
REQ-023 FILL SHALL count acks, write each into line storage at its offset, and on the final ack drop cyc, set line valid, load new tag, and pulse o_valid with the requested word the next cycle; ->IDLE.
REQ-024 Uncached read: IDLE->SINGLE; one strobe; on ack drop cyc, o_valid with i_wb_data the next cycle; line untouched.
REQ-025 Write (any cachability): IDLE->WRITE; one write strobe with registered data/sel; on ack drop cyc, no o_valid, ->IDLE.
REQ-026 Write hitting the valid line SHALL invalidate the line at acceptance (see REQ-033 for alternate).
REQ-027 o_wb_stb SHALL never assert without o_wb_cyc; stb drops once all strobes are accepted while cyc waits for acks.
REQ-028 i_wb_err in any busy state: drop cyc/stb same edge, clear line valid, pulse o_err next cycle, ->IDLE; no o_valid.
REQ-029 Acks arriving in IDLE SHALL be ignored.
REQ-030 Outstanding-ack counter SHALL be LGLINE+1 bits and never wrap.

Reset
REQ-031 On i_reset: state IDLE, line valid 0, o_wb_cyc/o_wb_stb/o_valid/o_err/o_busy 0, counters 0; o_data, o_wb_addr, o_wb_data, o_wb_sel, o_wb_we don't-care.
REQ-032 Reset mid-FILL/SINGLE/WRITE SHALL abort the cycle immediately, leave line invalid, produce no o_valid/o_err.

Configuration
REQ-033 Macro DLINE_WRITE_UPDATE_EN: when defined, a write hit updates line storage byte-wise per i_sel and keeps the line valid; when undefined, REQ-026 invalidation applies.

Structure
REQ-034 Shared package zipmem_pkg SHALL hold the state enum (IDLE, FILL, SINGLE, WRITE) and default LGLINE constant.
REQ-035 Line storage (2^LGLINE x DW, byte-writable, registered read) SHALL be sub-module dline_ram.

Verification
REQ-036 Read 0x0000100 cachable, zero-stall slave -> 8 strobes 0x100..0x107, o_valid once with word 0x100 data; repeat read 0x0000103 -> o_valid next cycle, no o_wb_cyc.
REQ-037 Read 0x1000000 i_cachable=0 -> one strobe, o_valid with slave data 0xDEADBEEF, line state unchanged.
REQ-038 Write 0x0000102 data 0x12345678 sel 4'hF after fill -> one write strobe; then read 0x102 -> refill (macro off) or hit returning 0x12345678 (macro on).
REQ-039 i_wb_err on 3rd fill ack -> cyc low same edge, o_err one pulse, next read 0x100 refetches full line.
REQ-040 i_reset asserted with i_wb_stall=1 mid-FILL -> cyc/stb low next cycle, no o_valid/o_err, o_busy 0.
